mono_mode_ctrl: RTL
===================

Name: mono_mode_ctrl

Overview:
Controller for the video colour/monochrome datapath between system_2MB video output and the VGA pins. It holds the display mode (colour, green, amber, white), taken from a PS/2 hotkey strobe or a CPU port write. Mode changes are deferred to the next frame boundary (VBlank rising edge) so a frame never tears mid-scan. It also runs a registered 2-stage luma pipeline, with sync and blank signals delayed to stay aligned with pixel data.

Parameters:
INIT_MODE, 2'd0, mode loaded on reset (0 colour, 1 green, 2 amber, 3 white)
HOLDOFF_CYC, 24'd2863600, hotkey holdoff in clk_28_636 cycles (100 ms); used only with MONO_KEY_HOLDOFF_EN

Ports:
clk_28_636  in  1  video clock; the block's only clock
reset  in  1  synchronous, active-high reset
key_strobe  in  1  1-cycle pulse from the hotkey decoder: advance mode
mode_wr  in  1  1-cycle CPU write strobe
mode_wdata  in  2  CPU-written mode
r_in/g_in/b_in  in  6 each  pixel colour from the video generator
hs_in/vs_in/hb_in/vb_in  in  1 each  HSync/VSync/HBlank/VBlank, aligned with r_in..b_in
r_out/g_out/b_out  out  6 each  processed pixel
hs_out/vs_out/hb_out/vb_out  out  1 each  sync/blank delayed by 2 cycles
mode  out  2  active mode
mode_pending  out  1  high while the requested mode differs from the active mode
mode_changed  out  1  1-cycle pulse when a commit occurs

Behaviour:
- Clock and reset: one clock, clk_28_636; reset is synchronous and active-high.
- Reset values:
  - mode = req = INIT_MODE.
  - mode_pending = 0, mode_changed = 0.
  - All pipeline registers, including pixel outputs, = 0.
  - hs_out = vs_out = hb_out = vb_out = 0.
  - Holdoff counter = 0; FSM in IDLE.
- Request register req[1:0]:
  - mode_wr: req <= mode_wdata.
  - Accepted key_strobe: req <= req+1, wrapping 3 to 0.
  - mode_wr and key_strobe in the same cycle: CPU write wins; the strobe is discarded and does not start holdoff.
- VBlank edge detect: vb_rise = vb_in & ~vb_d, where vb_d is vb_in registered.
- Commit FSM:
  - IDLE: go to WAIT when req != mode.
  - WAIT: mode_pending = 1.
    - If req returns to equal mode before vb_rise, go to IDLE with no commit and no pulse.
    - On vb_rise, go to COMMIT.
  - COMMIT (1 cycle): mode <= req as sampled on entry to COMMIT; mode_changed = 1; go to IDLE. A req update during COMMIT re-enters WAIT from IDLE on the next cycle.
  - Commits happen only on the VBlank rising edge. A request made while VBlank is already high waits for the next frame.
- Luma: Y = (54*R + 183*G + 18*B) >> 8.
  - Products are 14 bits; the sum fits in 14 bits.
  - The result fits in 6 bits (maximum 62); no saturation needed.
- Pipeline (advances every clock, independent of ce_pix):
  - Stage 1 registers the three products plus the input RGB and syncs.
  - Stage 2 registers the sum/shift, the mode mux, and the syncs.
  - Latency is exactly 2 cycles for both pixels and syncs.
- Mode mux in stage 2 uses the active mode register:
  - 0: RGB passthrough.
  - 1: (0, Y, 0).
  - 2: (Y, Y>>1, 0).
  - 3: (Y, Y, Y).
- Blanking: when the stage-2 hb or vb is set, r_out = g_out = b_out = 0 in every mode.
- Reset mid-frame: outputs zero on the next edge. The pipeline refills within 2 cycles after reset is released. A pending request is lost and req returns to INIT_MODE.

Optional Feature:
MONO_KEY_HOLDOFF_EN
- Defined:
  - An accepted key_strobe loads the holdoff counter with HOLDOFF_CYC-1.
  - key_strobe is ignored while the counter is nonzero; the counter decrements each cycle.
  - mode_wr is never blocked.
- Undefined: every key_strobe is accepted; no counter is synthesised.

Test Plan:
- Reset with INIT_MODE=0, then r/g/b_in = 10/20/30 with blanks low: exactly 2 cycles later outputs are 10/20/30, and hs_out tracks hs_in delayed by 2.
- mode_wr = 1 with mode_wdata = 3 in mid-frame: mode_pending = 1 and mode stays 0 until vb_in rises. One cycle after that edge, mode = 3 and mode_changed pulses for exactly one cycle. With r/g/b = 63/63/63, the output is 62/62/62.
- Mode 1, r/g/b = 63/0/0: output is 0/13/0. Mode 2, r/g/b = 0/63/0: output is 45/22/0.
- key_strobe four times within one frame, no holdoff: req wraps 0 to 1, 2, 3, 0. mode_pending drops, and there is no commit and no mode_changed at the next vb_rise.
- mode_wr (data 2) and key_strobe in the same cycle from req = 0: req = 2, commit to 2 at the next vb_rise.
- MONO_KEY_HOLDOFF_EN with HOLDOFF_CYC = 8: strobes at cycles 0 and 5 give req +1 only; a strobe at cycle 8 is accepted, giving req +2. Also assert hb_in during a white pixel: output is 0/0/0.

Source files
------------

// File: rtl/mono_mode_ctrl.sv
// Display-mode controller with frame-synchronous commit and 2-stage luma pipe.
// Optional hotkey holdoff counter enabled by defining MONO_KEY_HOLDOFF_EN.
module mono_mode_ctrl #(
  parameter logic [1:0]  INIT_MODE   = 2'd0
`ifdef MONO_KEY_HOLDOFF_EN
  ,
  parameter logic [23:0] HOLDOFF_CYC = 24'd2863600
`endif
) (
  input  logic       clk_28_636,
  input  logic       reset,
  input  logic       key_strobe,
  input  logic       mode_wr,
  input  logic [1:0] mode_wdata,
  input  logic [5:0] r_in,
  input  logic [5:0] g_in,
  input  logic [5:0] b_in,
  input  logic       hs_in,
  input  logic       vs_in,
  input  logic       hb_in,
  input  logic       vb_in,
  output logic [5:0] r_out,
  output logic [5:0] g_out,
  output logic [5:0] b_out,
  output logic       hs_out,
  output logic       vs_out,
  output logic       hb_out,
  output logic       vb_out,
  output logic [1:0] mode,
  output logic       mode_pending,
  output logic       mode_changed
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_COMMIT
  } state_t;

  state_t     state;
  state_t     nxt;
  logic       load_mode;
  logic [1:0] req;
  logic       vb_d;
  logic       vb_rise;
  logic       key_ok;

`ifdef MONO_KEY_HOLDOFF_EN
  logic [23:0] hold_cnt;

  assign key_ok = key_strobe & ~mode_wr & (hold_cnt == 24'd0);

  always_ff @(posedge clk_28_636) begin
    if (reset)
      hold_cnt <= 24'd0;
    else if (key_ok)
      hold_cnt <= HOLDOFF_CYC - 24'd1;
    else if (hold_cnt != 24'd0)
      hold_cnt <= hold_cnt - 24'd1;
  end
`else
  // CPU write in the same cycle swallows the strobe
  assign key_ok = key_strobe & ~mode_wr;
`endif

  always_ff @(posedge clk_28_636) begin
    if (reset)
      req <= INIT_MODE;
    else if (mode_wr)
      req <= mode_wdata;
    else if (key_ok)
      req <= req + 2'd1;
  end

  always_ff @(posedge clk_28_636) begin
    if (reset)
      vb_d <= 1'b0;
    else
      vb_d <= vb_in;
  end

  assign vb_rise = vb_in & ~vb_d;

  always_ff @(posedge clk_28_636) begin
    if (reset) begin
      state <= S_IDLE;
      mode  <= INIT_MODE;
    end else begin
      state <= nxt;
      if (load_mode)
        mode <= req;
    end
  end

  always_comb begin
    nxt          = state;
    load_mode    = 1'b0;
    mode_pending = 1'b0;
    mode_changed = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (req != mode)
          nxt = S_WAIT;
      end
      S_WAIT: begin
        mode_pending = 1'b1;
        if (req == mode) begin
          nxt = S_IDLE;
        end else if (vb_rise) begin
          nxt       = S_COMMIT;
          load_mode = 1'b1;
        end
      end
      S_COMMIT: begin
        mode_changed = 1'b1;
        nxt          = S_IDLE;
      end
      default: nxt = S_IDLE;
    endcase
  end

  logic [13:0] s1_pr;
  logic [13:0] s1_pg;
  logic [13:0] s1_pb;
  logic [5:0]  s1_r;
  logic [5:0]  s1_g;
  logic [5:0]  s1_b;
  logic        s1_hs;
  logic        s1_vs;
  logic        s1_hb;
  logic        s1_vb;

  always_ff @(posedge clk_28_636) begin
    if (reset) begin
      s1_pr <= 14'd0;
      s1_pg <= 14'd0;
      s1_pb <= 14'd0;
      s1_r  <= 6'd0;
      s1_g  <= 6'd0;
      s1_b  <= 6'd0;
      s1_hs <= 1'b0;
      s1_vs <= 1'b0;
      s1_hb <= 1'b0;
      s1_vb <= 1'b0;
    end else begin
      s1_pr <= 14'(r_in) * 14'd54;
      s1_pg <= 14'(g_in) * 14'd183;
      s1_pb <= 14'(b_in) * 14'd18;
      s1_r  <= r_in;
      s1_g  <= g_in;
      s1_b  <= b_in;
      s1_hs <= hs_in;
      s1_vs <= vs_in;
      s1_hb <= hb_in;
      s1_vb <= vb_in;
    end
  end

  // Coefficients sum to 255, so the 14-bit sum never overflows
  logic [13:0] y_sum;
  logic [5:0]  y;
  logic [5:0]  mr;
  logic [5:0]  mg;
  logic [5:0]  mb;

  assign y_sum = s1_pr + s1_pg + s1_pb;
  assign y     = y_sum[13:8];

  always_comb begin
    mr = s1_r;
    mg = s1_g;
    mb = s1_b;
    unique case (1'b1)
      (mode == 2'd1): begin
        mr = 6'd0;
        mg = y;
        mb = 6'd0;
      end
      (mode == 2'd2): begin
        mr = y;
        mg = {1'b0, y[5:1]};
        mb = 6'd0;
      end
      (mode == 2'd3): begin
        mr = y;
        mg = y;
        mb = y;
      end
      default: ;
    endcase
    if (s1_hb | s1_vb) begin
      mr = 6'd0;
      mg = 6'd0;
      mb = 6'd0;
    end
  end

  always_ff @(posedge clk_28_636) begin
    if (reset) begin
      r_out  <= 6'd0;
      g_out  <= 6'd0;
      b_out  <= 6'd0;
      hs_out <= 1'b0;
      vs_out <= 1'b0;
      hb_out <= 1'b0;
      vb_out <= 1'b0;
    end else begin
      r_out  <= mr;
      g_out  <= mg;
      b_out  <= mb;
      hs_out <= s1_hs;
      vs_out <= s1_vs;
      hb_out <= s1_hb;
      vb_out <= s1_vb;
    end
  end

endmodule
